// File: rtl/motion_pkg.sv
// Shared types and constants for the per-player movement engine.
package motion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HORIZ,
    VERT,
    COLLIDE,
    COMMIT
  } state_t;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;

endpackage

// File: rtl/player_motion_divider.sv
// Modulo-N frame divider: counts enabled frames, flags the frame that wraps.
module frame_divider #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = en && !clr && (cnt_q == W'(N - 1));
    cnt_d   = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-player movement engine: once per frame, turns the latched button byte
// into a new position, velocity, facing and walk frame, committed atomically.
module player_motion
  import motion_pkg::*;
#(
  parameter int SPR_W       = 46,
  parameter int SPR_H       = 60,
  parameter int SPAWN_X     = 50,
  parameter int SPAWN_Y     = 0,
  parameter int PLT_X       = 20,
  parameter int PLT_Y       = 410,
  parameter int PLT_W       = 400,
  parameter int STEP_X      = 5,
  parameter int JUMP_VEL    = 12,
  parameter int MAX_FALL    = 10,
  parameter int GRAV_DIV    = 1,
  parameter int ANIM_DIV    = 6,
  parameter int ANIM_FRAMES = 6,
  parameter int SCREEN_W    = SCREEN_W_PX,
  parameter int SCREEN_H    = SCREEN_H_PX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] buttons,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing_right,
  output logic [2:0] anim_frame,
  output logic       grounded,
  output logic       update_done
);

  localparam logic signed [11:0] SPR_W_S  = 12'(SPR_W);
  localparam logic signed [11:0] SPR_H_S  = 12'(SPR_H);
  localparam logic signed [11:0] PLT_L    = 12'(PLT_X);
  localparam logic signed [11:0] PLT_R    = 12'(PLT_X + PLT_W);
  localparam logic signed [11:0] PLT_T    = 12'(PLT_Y);
  localparam logic signed [11:0] LAND_Y   = 12'(PLT_Y - SPR_H);
  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - SPR_W);
  localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_H - 1);
  localparam logic signed [11:0] STEP     = 12'(STEP_X);
  localparam logic signed [11:0] SPAWN_XS = 12'(SPAWN_X);
  localparam logic signed [11:0] SPAWN_YS = 12'(SPAWN_Y);
  localparam logic signed [7:0]  V_JUMP   = 8'(-JUMP_VEL);
  localparam logic signed [7:0]  V_MAX    = 8'(MAX_FALL);
  localparam logic [2:0]         ANIM_LAST = 3'(ANIM_FRAMES - 1);

  state_t state_q, state_d;
  logic [7:0] btn_q, btn_d;
  logic signed [11:0] wx_q, wx_d, wy_q, wy_d;
  logic signed [7:0]  wvel_q, wvel_d, vel_q, vel_d;
  logic wgnd_q, wgnd_d, wface_q, wface_d, moving_q, moving_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [2:0] anim_q, anim_d;
  logic facing_q, facing_d, grounded_q, grounded_d, done_q, done_d;

  logic left, right, jump, overlap, land;
  logic signed [11:0] x_old, y_old;
  logic grav_en, grav_exp, anim_en, anim_clr, anim_exp;
  logic unused_btn;

  // Decode and collision terms kept apart from the next-state block so the
  // divider expiry flags do not form a combinational loop through it.
  always_comb begin
    left       = ~btn_q[BTN_LEFT];
    right      = ~btn_q[BTN_RIGHT];
    jump       = ~btn_q[BTN_UP];
    unused_btn = ^{btn_q[7:4], btn_q[BTN_DOWN]};
    x_old      = signed'({2'b00, pos_x_q});
    y_old      = signed'({2'b00, pos_y_q});
    overlap    = (wx_q + SPR_W_S >= PLT_L) && (wx_q <= PLT_R);
    land       = (state_q == COLLIDE) && !wvel_q[7] && (y_old + SPR_H_S <= PLT_T)
                 && (wy_q + SPR_H_S >= PLT_T) && overlap;
    grav_en    = (state_q == VERT) && !grounded_q;
    anim_en    = (state_q == COMMIT) && moving_q;
    anim_clr   = (state_q == COMMIT) && !moving_q;
  end

  frame_divider #(.N(GRAV_DIV)) u_grav_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (land),
    .en      (grav_en),
    .expired (grav_exp)
  );

  frame_divider #(.N(ANIM_DIV)) u_anim_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (anim_clr),
    .en      (anim_en),
    .expired (anim_exp)
  );

  always_comb begin
    state_d    = state_q;
    btn_d      = btn_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    wvel_d     = wvel_q;
    wgnd_d     = wgnd_q;
    wface_d    = wface_q;
    moving_d   = moving_q;
    vel_d      = vel_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    anim_d     = anim_q;
    facing_d   = facing_q;
    grounded_d = grounded_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          btn_d   = buttons;
          state_d = HORIZ;
        end
      end
      HORIZ: begin
        wx_d     = x_old;
        wface_d  = facing_q;
        wgnd_d   = grounded_q;
        moving_d = left ^ right;
        if (left && !right) begin
          wface_d = 1'b0;
          wx_d    = (x_old < STEP) ? '0 : x_old - STEP;
        end else if (right && !left) begin
          wface_d = 1'b1;
          wx_d    = (x_old > X_MAX - STEP) ? X_MAX : x_old + STEP;
        end
        state_d = VERT;
      end
      VERT: begin
        wvel_d = vel_q;
        // A jump leaves the ground here so COLLIDE does not pin y back down.
        if (jump && grounded_q) begin
          wvel_d = V_JUMP;
          wgnd_d = 1'b0;
        end else if (!grounded_q && grav_exp) begin
          wvel_d = (vel_q >= V_MAX) ? V_MAX : vel_q + 8'sd1;
        end
        wy_d    = y_old + signed'({{4{wvel_d[7]}}, wvel_d});
        state_d = COLLIDE;
      end
      COLLIDE: begin
        if (land) begin
          wy_d   = LAND_Y;
          wvel_d = '0;
          wgnd_d = 1'b1;
        end else begin
          if (wgnd_q && !overlap) begin
            wgnd_d = 1'b0;
          end
          if (wy_q < 0) begin
            wy_d = '0;
            if (wvel_q[7]) begin
              wvel_d = '0;
            end
          end else if (wy_q > Y_MAX) begin
            wx_d   = SPAWN_XS;
            wy_d   = SPAWN_YS;
            wvel_d = '0;
            wgnd_d = 1'b0;
          end
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        pos_x_d    = wx_q[9:0];
        pos_y_d    = wy_q[9:0];
        vel_d      = wvel_q;
        facing_d   = wface_q;
        grounded_d = wgnd_q;
        if (!moving_q) begin
          anim_d = '0;
        end else if (anim_exp) begin
          anim_d = (anim_q == ANIM_LAST) ? '0 : anim_q + 3'd1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      btn_q      <= '1;
      wx_q       <= '0;
      wy_q       <= '0;
      wvel_q     <= '0;
      wgnd_q     <= 1'b0;
      wface_q    <= 1'b0;
      moving_q   <= 1'b0;
      vel_q      <= '0;
      pos_x_q    <= 10'(SPAWN_X);
      pos_y_q    <= 10'(SPAWN_Y);
      anim_q     <= '0;
      facing_q   <= 1'b0;
      grounded_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      wvel_q     <= wvel_d;
      wgnd_q     <= wgnd_d;
      wface_q    <= wface_d;
      moving_q   <= moving_d;
      vel_q      <= vel_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      anim_q     <= anim_d;
      facing_q   <= facing_d;
      grounded_q <= grounded_d;
      done_q     <= done_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign facing_right = facing_q;
  assign anim_frame   = anim_q;
  assign grounded     = grounded_q;
  assign update_done  = done_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed table, corner sequences, and random
// frames checked against a frame-level behavioural model.
module tb_player_motion;
  import motion_pkg::*;

  localparam int M_SPR_W = 46, M_SPR_H = 60, M_SPAWN_X = 50, M_SPAWN_Y = 0;
  localparam int M_PLT_X = 20, M_PLT_Y = 410, M_PLT_W = 400, M_STEP = 5;
  localparam int M_JUMP = 12, M_MAXF = 10, M_GDIV = 1, M_ADIV = 6, M_AFR = 6;
  localparam int M_SW = 640, M_SH = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic [7:0] buttons = 8'hFF;
  logic [7:0] buttons_b = 8'hFD;
  logic [9:0] pos_x, pos_y, pos_x_b, pos_y_b;
  logic [2:0] anim_frame, anim_b;
  logic facing_right, grounded, update_done, facing_b, grounded_b, done_b;

  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  player_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .buttons(buttons),
    .pos_x(pos_x), .pos_y(pos_y), .facing_right(facing_right),
    .anim_frame(anim_frame), .grounded(grounded), .update_done(update_done)
  );

  player_motion #(.SPAWN_X(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .buttons(buttons_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .facing_right(facing_b),
    .anim_frame(anim_b), .grounded(grounded_b), .update_done(done_b)
  );

  // Behavioural model state, one update per frame.
  int mx, my, mvel, mgnd, mface, manim, madiv, mgcnt;

  typedef struct {
    logic [7:0] btn;
    int         n;
    int         x;
    int         y;
    logic       face;
    int         anim;
    logic       gnd;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic string outs();
    return $sformatf("got x=%0d y=%0d face=%0b anim=%0d gnd=%0b", pos_x, pos_y,
                     facing_right, anim_frame, grounded);
  endfunction

  task automatic model_reset();
    mx = M_SPAWN_X; my = M_SPAWN_Y; mvel = 0; mgnd = 0;
    mface = 0; manim = 0; madiv = 0; mgcnt = 0;
  endtask

  task automatic model_frame(input logic [7:0] b);
    bit l, r, j, ov;
    int nx, ny;
    l = !b[1]; r = !b[0]; j = !b[3];
    nx = mx;
    if (l && !r) begin
      mface = 0;
      nx = (mx - M_STEP < 0) ? 0 : mx - M_STEP;
    end else if (r && !l) begin
      mface = 1;
      nx = (mx + M_STEP > M_SW - M_SPR_W) ? M_SW - M_SPR_W : mx + M_STEP;
    end
    if (j && mgnd != 0) begin
      mvel = -M_JUMP;
      mgnd = 0;
    end else if (mgnd == 0) begin
      mgcnt++;
      if (mgcnt >= M_GDIV) begin
        mgcnt = 0;
        if (mvel < M_MAXF) mvel++;
      end
    end
    ny = my + mvel;
    ov = (nx + M_SPR_W >= M_PLT_X) && (nx <= M_PLT_X + M_PLT_W);
    if (mvel >= 0 && my + M_SPR_H <= M_PLT_Y && ny + M_SPR_H >= M_PLT_Y && ov) begin
      ny = M_PLT_Y - M_SPR_H; mvel = 0; mgnd = 1; mgcnt = 0;
    end else begin
      if (mgnd != 0 && !ov) mgnd = 0;
      if (ny < 0) begin
        ny = 0;
        if (mvel < 0) mvel = 0;
      end else if (ny > M_SH - 1) begin
        nx = M_SPAWN_X; ny = M_SPAWN_Y; mvel = 0; mgnd = 0;
      end
    end
    if (l ^ r) begin
      madiv++;
      if (madiv == M_ADIV) begin
        madiv = 0;
        manim = (manim + 1) % M_AFR;
      end
    end else begin
      madiv = 0;
      manim = 0;
    end
    mx = nx;
    my = ny;
  endtask

  // One frame: pulse the tick, scramble buttons afterwards, optionally fire a
  // stray tick while busy, and check latency, pulse width and model outputs.
  task automatic do_tick(input logic [7:0] b, input bit glitch);
    int cyc;
    bit ok;
    @(negedge clk);
    buttons = b;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    buttons = 8'($urandom);
    model_frame(b);
    cyc = 0;
    while (!update_done && cyc < 12) begin
      @(negedge clk);
      cyc++;
      frame_tick = glitch && (cyc == 1);
    end
    frame_tick = 1'b0;
    ok = (cyc == 4);
    @(negedge clk);
    check("latency", ok && !update_done,
          $sformatf("update_done after %0d cycles, held=%0b; want 4 cycles, one-cycle pulse",
                    cyc, update_done));
    check("model", int'(pos_x) == mx && int'(pos_y) == my && int'(facing_right) == mface &&
          int'(anim_frame) == manim && int'(grounded) == mgnd,
          $sformatf("%s want x=%0d y=%0d face=%0d anim=%0d gnd=%0d", outs(), mx, my,
                    mface, manim, mgnd));
  endtask

  task automatic check_reset_vals(input string name);
    check(name, pos_x == 10'd50 && pos_y == 10'd0 && !facing_right && anim_frame == 3'd0 &&
          !grounded && !update_done,
          $sformatf("%s done=%0b want x=50 y=0 face=0 anim=0 gnd=0 done=0", outs(),
                    update_done));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit first_b, seen;
    int n, prev_y;

    vecs[0]  = '{8'hFF, 1,  50,   1, 1'b0, 0, 1'b0};
    vecs[1]  = '{8'hFF, 1,  50,   3, 1'b0, 0, 1'b0};
    vecs[2]  = '{8'hFF, 1,  50,   6, 1'b0, 0, 1'b0};
    vecs[3]  = '{8'hFF, 7,  50,  55, 1'b0, 0, 1'b0};
    vecs[4]  = '{8'hFF, 29, 50, 345, 1'b0, 0, 1'b0};
    vecs[5]  = '{8'hFF, 1,  50, 350, 1'b0, 0, 1'b1};
    vecs[6]  = '{8'hF7, 1,  50, 338, 1'b0, 0, 1'b0};
    vecs[7]  = '{8'hFF, 1,  50, 327, 1'b0, 0, 1'b0};
    vecs[8]  = '{8'hFF, 24, 50, 350, 1'b0, 0, 1'b1};
    vecs[9]  = '{8'hFE, 6,  80, 350, 1'b1, 1, 1'b1};
    vecs[10] = '{8'hFF, 1,  80, 350, 1'b1, 0, 1'b1};
    vecs[11] = '{8'hFD, 6,  50, 350, 1'b0, 1, 1'b1};
    vecs[12] = '{8'hFC, 1,  50, 350, 1'b0, 0, 1'b1};
    vecs[13] = '{8'hFE, 1,  55, 350, 1'b1, 0, 1'b1};
    vecs[14] = '{8'hFC, 1,  55, 350, 1'b1, 0, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    model_reset();

    first_b = 1'b1;
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        do_tick(vecs[i].btn, 1'b0);
        if (first_b) begin
          first_b = 1'b0;
          check("left_clamp", pos_x_b == 10'd0 && pos_y_b == 10'd1 && !facing_b,
                $sformatf("x=%0d y=%0d face=%0b want x=0 y=1 face=0", pos_x_b, pos_y_b,
                          facing_b));
        end
      end
      check($sformatf("vec%0d", i),
            int'(pos_x) == vecs[i].x && int'(pos_y) == vecs[i].y &&
            facing_right == vecs[i].face && int'(anim_frame) == vecs[i].anim &&
            grounded == vecs[i].gnd,
            $sformatf("%s want x=%0d y=%0d face=%0b anim=%0d gnd=%0b", outs(), vecs[i].x,
                      vecs[i].y, vecs[i].face, vecs[i].anim, vecs[i].gnd));
    end

    n = 0;
    while (grounded && n < 200) begin
      do_tick(8'hFE, 1'b0);
      n++;
    end
    check("walk_off", !grounded && pos_x == 10'd425 && pos_y == 10'd350,
          $sformatf("%s want x=425 y=350 gnd=0", outs()));

    n = 0;
    prev_y = int'(pos_y);
    while (pos_y != 10'd0 && n < 60) begin
      prev_y = int'(pos_y);
      do_tick(8'hFE, 1'b0);
      n++;
    end
    check("respawn", pos_y == 10'd0 && pos_x == 10'd50 && !grounded && prev_y == 475,
          $sformatf("%s prev_y=%0d want x=50 y=0 gnd=0 prev_y=475", outs(), prev_y));

    repeat (3) do_tick(8'hFE, 1'b0);
    @(negedge clk);
    buttons = 8'hFE;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    check("mid_reset_state", dut.state_q == IDLE,
          $sformatf("state=%0d want IDLE", dut.state_q));
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (update_done) seen = 1'b1;
    end
    check("no_done_after_reset", !seen, $sformatf("update_done seen=%0b want 0", seen));
    do_tick(8'hFF, 1'b0);
    check("post_reset_fall", pos_y == 10'd1, $sformatf("%s want y=1", outs()));

    for (int i = 0; i < 300; i++) begin
      do_tick(8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
